// File: rtl/pbuf2ddr.sv
// pbuf2ddr: drains the four pbuf banks into a DDR write stream via a credit-tracked FIFO.
// Define PBUF2DDR_CLEAR_EN to enable the read-and-clear path for gradient dumps.
module pbuf2ddr #(
  parameter int BUF_DEPTH  = 256,
  parameter int ADDR_W     = $clog2(BUF_DEPTH),
  parameter int DATA_W     = 16,
  parameter int BATCH      = 32,
  parameter int DDR_W      = DATA_W * BATCH,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 done,
  input  logic [7:0]           conf_trans_num,
  input  logic [1:0]           conf_grp_sel,
  input  logic                 conf_all_banks,
  input  logic                 conf_clear,
  output logic [ADDR_W-1:0]    pbuf_rd_addr,
  output logic [3:0]           pbuf_rd_en,
  input  logic [4*DDR_W-1:0]   pbuf_rd_data,
  output logic [ADDR_W-1:0]    pbuf_clr_addr,
  output logic [3:0]           pbuf_clr_en,
  output logic [DDR_W-1:0]     ddr_data,
  output logic                 ddr_valid,
  input  logic                 ddr_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [7:0] n_q, n_d;
  logic [7:0] addr_q, addr_d;
  logic [1:0] grp_q, grp_d;
  logic [1:0] bank_q, bank_d;
  logic       all_q, all_d;
  logic       clear_q, clear_d;

  logic [3:0]        rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        rd_bank_q, rd_bank_d;

  logic [RD_LAT-1:0] sr_v_q, sr_v_d;
  logic [1:0]        sr_bank_q [RD_LAT];
  logic [1:0]        sr_bank_d [RD_LAT];
  logic [ADDR_W-1:0] sr_addr_q [RD_LAT];
  logic [ADDR_W-1:0] sr_addr_d [RD_LAT];

  logic [DDR_W-1:0] fifo_q [FIFO_DEPTH];
  logic [DDR_W-1:0] fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;

  logic       idle, go, issue, last;
  logic       push, pop;
  logic       all_e;
  logic [7:0] n_e, addr_e;
  logic [1:0] grp_e, bank_e, iss_bank;
  int         inflight;
  logic [DDR_W-1:0] cap_data;

  assign done         = (state_q == S_IDLE);
  assign pbuf_rd_en   = rd_en_q;
  assign pbuf_rd_addr = rd_addr_q;
  assign ddr_valid    = (occ_q != '0);
  assign ddr_data     = fifo_q[rd_ptr_q];

  assign push     = sr_v_q[RD_LAT-1];
  assign pop      = ddr_valid && ddr_ready;
  assign cap_data = pbuf_rd_data[int'(sr_bank_q[RD_LAT-1]) * DDR_W +: DDR_W];

  always_comb begin
    idle   = (state_q == S_IDLE);
    go     = idle && start;
    // The first read is issued off the start pulse itself, so use live config.
    n_e    = idle ? conf_trans_num : n_q;
    grp_e  = idle ? conf_grp_sel : grp_q;
    all_e  = idle ? conf_all_banks : all_q;
    addr_e = idle ? 8'd0 : addr_q;
    bank_e = idle ? 2'd0 : bank_q;

    inflight = int'(|rd_en_q);
    for (int i = 0; i < RD_LAT; i++) inflight += int'(sr_v_q[i]);

    issue    = (go || state_q == S_RUN) &&
               ((inflight + int'(occ_q) - int'(pop)) < FIFO_DEPTH);
    last     = (addr_e == n_e) && (!all_e || bank_e == 2'd3);
    iss_bank = all_e ? bank_e : grp_e;

    state_d   = state_q;
    n_d       = n_q;
    grp_d     = grp_q;
    all_d     = all_q;
    clear_d   = clear_q;
    addr_d    = addr_q;
    bank_d    = bank_q;
    rd_en_d   = 4'b0000;
    rd_addr_d = rd_addr_q;
    rd_bank_d = rd_bank_q;

    if (go) begin
      n_d     = conf_trans_num;
      grp_d   = conf_grp_sel;
      all_d   = conf_all_banks;
      clear_d = conf_clear;
      addr_d  = 8'd0;
      bank_d  = 2'd0;
      state_d = S_RUN;
    end

    if (issue) begin
      rd_en_d   = 4'b0001 << iss_bank;
      rd_addr_d = ADDR_W'(addr_e);
      rd_bank_d = iss_bank;
      if (all_e && bank_e != 2'd3) begin
        bank_d = bank_e + 2'd1;
      end else begin
        bank_d = 2'd0;
        addr_d = addr_e + 8'd1;
      end
      if (last) state_d = S_DRAIN;
    end

    if (state_q == S_DRAIN && inflight == 0 &&
        int'(occ_q) == int'(pop)) begin
      state_d = S_IDLE;
    end

    sr_v_d[0]    = |rd_en_q;
    sr_bank_d[0] = rd_bank_q;
    sr_addr_d[0] = rd_addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      sr_v_d[i]    = sr_v_q[i-1];
      sr_bank_d[i] = sr_bank_q[i-1];
      sr_addr_d[i] = sr_addr_q[i-1];
    end

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = cap_data;
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      grp_q     <= '0;
      all_q     <= 1'b0;
      clear_q   <= 1'b0;
      addr_q    <= '0;
      bank_q    <= '0;
      rd_en_q   <= '0;
      rd_addr_q <= '0;
      rd_bank_q <= '0;
      sr_v_q    <= '0;
      sr_bank_q <= '{default: '0};
      sr_addr_q <= '{default: '0};
      fifo_q    <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      grp_q     <= grp_d;
      all_q     <= all_d;
      clear_q   <= clear_d;
      addr_q    <= addr_d;
      bank_q    <= bank_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_bank_q <= rd_bank_d;
      sr_v_q    <= sr_v_d;
      sr_bank_q <= sr_bank_d;
      sr_addr_q <= sr_addr_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
    end
  end

`ifdef PBUF2DDR_CLEAR_EN
  logic clr_hit;

  // Hold off the clear if a younger read of the same entry is still in flight.
  always_comb begin
    clr_hit = |rd_en_q &&
              rd_bank_q == sr_bank_q[RD_LAT-1] &&
              rd_addr_q == sr_addr_q[RD_LAT-1];
    for (int i = 0; i < RD_LAT - 1; i++) begin
      if (sr_v_q[i] &&
          sr_bank_q[i] == sr_bank_q[RD_LAT-1] &&
          sr_addr_q[i] == sr_addr_q[RD_LAT-1]) begin
        clr_hit = 1'b1;
      end
    end
  end

  assign pbuf_clr_en   = (clear_q && push && !clr_hit) ?
                         (4'b0001 << sr_bank_q[RD_LAT-1]) : 4'b0000;
  assign pbuf_clr_addr = sr_addr_q[RD_LAT-1];
`else
  logic unused_clr;

  assign unused_clr    = ^{clear_q, sr_addr_q[RD_LAT-1]};
  assign pbuf_clr_en   = 4'b0000;
  assign pbuf_clr_addr = '0;
`endif

endmodule

// File: tb/tb_pbuf2ddr.sv
// tb_pbuf2ddr: directed bench for pbuf2ddr with a behavioural pbuf model.
// Clear-path expectations follow PBUF2DDR_CLEAR_EN.
module tb_pbuf2ddr;

  localparam int DATA_W = 16;
  localparam int BATCH  = 32;
  localparam int W      = DATA_W * BATCH;
  localparam int RD_LAT = 2;
  localparam int AW     = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             done;
  logic [7:0]       conf_trans_num = '0;
  logic [1:0]       conf_grp_sel = '0;
  logic             conf_all_banks = 1'b0;
  logic             conf_clear = 1'b0;
  logic [AW-1:0]    pbuf_rd_addr;
  logic [3:0]       pbuf_rd_en;
  logic [4*W-1:0]   pbuf_rd_data;
  logic [AW-1:0]    pbuf_clr_addr;
  logic [3:0]       pbuf_clr_en;
  logic [W-1:0]     ddr_data;
  logic             ddr_valid;
  logic             ddr_ready = 1'b1;

  pbuf2ddr #(
    .BUF_DEPTH (256),
    .DATA_W    (DATA_W),
    .BATCH     (BATCH),
    .RD_LAT    (RD_LAT),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .done          (done),
    .conf_trans_num(conf_trans_num),
    .conf_grp_sel  (conf_grp_sel),
    .conf_all_banks(conf_all_banks),
    .conf_clear    (conf_clear),
    .pbuf_rd_addr  (pbuf_rd_addr),
    .pbuf_rd_en    (pbuf_rd_en),
    .pbuf_rd_data  (pbuf_rd_data),
    .pbuf_clr_addr (pbuf_clr_addr),
    .pbuf_clr_en   (pbuf_clr_en),
    .ddr_data      (ddr_data),
    .ddr_valid     (ddr_valid),
    .ddr_ready     (ddr_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // pbuf model: sampled mid-cycle, data visible over the edge RD_LAT cycles on.
  logic [W-1:0]   mem [4][256];
  logic [4*W-1:0] pipe [RD_LAT+1];
  logic [4*W-1:0] rdw;
  assign pbuf_rd_data = pipe[RD_LAT];

  always @(negedge clk) begin
    rdw = '0;
    for (int b = 0; b < 4; b++)
      if (pbuf_rd_en[b]) rdw[b*W +: W] = mem[b][pbuf_rd_addr];
    for (int b = 0; b < 4; b++)
      if (pbuf_clr_en[b]) mem[b][pbuf_clr_addr] = '0;
    for (int i = RD_LAT; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = rdw;
  end

  logic [W-1:0] got_q [$];
  int           got_cyc [$];
  int           rd_cyc [$];
  int           clr_cyc [$];
  logic [3:0]   clr_en_q [$];
  logic [7:0]   clr_addr_q [$];
  logic         stall = 1'b0;
  logic [W-1:0] hold = '0;

  always @(negedge clk) begin
    if (stall) begin
      checks++;
      assert (ddr_valid === 1'b1 && ddr_data === hold) else begin
        failures++;
        $error("FAIL hold: valid=%b data=%h expected %h", ddr_valid, ddr_data, hold);
      end
    end
    stall = ddr_valid && !ddr_ready && !rst;
    hold  = ddr_data;
    if (ddr_valid && ddr_ready && !rst) begin
      got_q.push_back(ddr_data);
      got_cyc.push_back(cyc);
    end
    if (pbuf_rd_en != 4'b0000) begin
      rd_cyc.push_back(cyc);
      checks++;
      assert ($onehot(pbuf_rd_en)) else begin
        failures++;
        $error("FAIL rd_en_onehot: got %b", pbuf_rd_en);
      end
    end
    if (pbuf_clr_en != 4'b0000) begin
      clr_cyc.push_back(cyc);
      clr_en_q.push_back(pbuf_clr_en);
      clr_addr_q.push_back(pbuf_clr_addr);
    end
  end

  function automatic logic [W-1:0] fillw(input int v);
    logic [DATA_W-1:0] e;
    e = DATA_W'(v);
    return {BATCH{e}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    got_cyc.delete();
    rd_cyc.delete();
    clr_cyc.delete();
    clr_en_q.delete();
    clr_addr_q.delete();
  endtask

  int start_cyc;
  int done_cyc;

  task automatic kick(input logic [7:0] n, input logic [1:0] grp,
                      input logic all, input logic clr);
    conf_trans_num = n;
    conf_grp_sel   = grp;
    conf_all_banks = all;
    conf_clear     = clr;
    start          = 1'b1;
    start_cyc      = cyc;
    step();
    start          = 1'b0;
    conf_trans_num = 8'hff;
    conf_grp_sel   = 2'd3;
    conf_all_banks = 1'b1;
    conf_clear     = ~clr;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n;
    n = 0;
    while (!done && n < budget) begin
      if (rnd) ddr_ready = ($urandom_range(0, 99) < 30);
      step();
      n++;
    end
    ddr_ready = 1'b1;
    chk("done_timeout", 32'(done), 32'd1);
    done_cyc = cyc;
  endtask

  int mism;

  initial begin
    for (int i = 0; i <= RD_LAT; i++) pipe[i] = '0;
    repeat (3) step();

    chk("rst_done", 32'(done), 32'd1);
    chk("rst_valid", 32'(ddr_valid), 32'd0);
    chkw("rst_data", ddr_data, '0);
    chk("rst_rd_en", 32'(pbuf_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(pbuf_rd_addr), 32'd0);
    chk("rst_clr_en", 32'(pbuf_clr_en), 32'd0);
    chk("rst_clr_addr", 32'(pbuf_clr_addr), 32'd0);
    rst = 1'b0;
    step();

    // single bank 2, N=7
    for (int a = 0; a < 8; a++) mem[2][a] = fillw(a + 1);
    clear_logs();
    kick(8'd7, 2'd2, 1'b0, 1'b0);
    chk("t1_busy", 32'(done), 32'd0);
    chk("t1_rd_en", 32'(pbuf_rd_en), 32'b0100);
    chk("t1_rd_addr", 32'(pbuf_rd_addr), 32'd0);
    wait_done(200, 1'b0);
    chk("t1_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < got_q.size() && i < 8; i++)
      chkw($sformatf("t1_word%0d", i), got_q[i], fillw(i + 1));
    if (got_q.size() == 8) begin
      chk("t1_first_lat", 32'(got_cyc[0] - start_cyc), 32'(RD_LAT + 2));
      chk("t1_no_gaps", 32'(got_cyc[7] - got_cyc[0]), 32'd7);
      chk("t1_done_rise", 32'(done_cyc), 32'(got_cyc[7] + 1));
    end

    // all banks, N=1
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 2; a++) mem[b][a] = fillw(16 * a + b);
    clear_logs();
    kick(8'd1, 2'd2, 1'b1, 1'b0);
    wait_done(200, 1'b0);
    chk("t2_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < got_q.size() && i < 8; i++)
      chkw($sformatf("t2_word%0d", i), got_q[i], fillw((i / 4) * 16 + (i % 4)));

    // backpressure, N=255 on bank 0
    for (int a = 0; a < 256; a++) mem[0][a] = fillw(a * 3 + 7);
    clear_logs();
    kick(8'd255, 2'd0, 1'b0, 1'b0);
    wait_done(6000, 1'b1);
    chk("t3_count", 32'(got_q.size()), 32'd256);
    mism = 0;
    for (int i = 0; i < got_q.size() && i < 256; i++)
      if (got_q[i] !== fillw(i * 3 + 7)) mism++;
    chk("t3_order", 32'(mism), 32'd0);

    // reset at the 5th handshake of N=15
    for (int a = 0; a < 16; a++) mem[3][a] = fillw(a + 100);
    clear_logs();
    kick(8'd15, 2'd3, 1'b0, 1'b0);
    for (int n = 0; n < 100 && got_q.size() < 5; n++) step();
    rst = 1'b1;
    ddr_ready = 1'b0;
    step();
    rst = 1'b0;
    ddr_ready = 1'b1;
    chk("t4_valid", 32'(ddr_valid), 32'd0);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_rd_en", 32'(pbuf_rd_en), 32'd0);
    repeat (10) step();
    chk("t4_no_stale", 32'(got_q.size()), 32'd5);
    if (got_q.size() >= 5) chkw("t4_word4", got_q[4], fillw(104));
    clear_logs();
    kick(8'd0, 2'd3, 1'b0, 1'b0);
    wait_done(100, 1'b0);
    chk("t4_n0_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) chkw("t4_n0_word", got_q[0], fillw(100));

    // start while busy
    for (int a = 0; a < 8; a++) mem[1][a] = fillw(a + 200);
    clear_logs();
    kick(8'd7, 2'd1, 1'b0, 1'b0);
    step();
    step();
    conf_trans_num = 8'd2;
    conf_grp_sel   = 2'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200, 1'b0);
    chk("t5_count", 32'(got_q.size()), 32'd8);
    if (got_q.size() == 8) begin
      chkw("t5_first", got_q[0], fillw(200));
      chkw("t5_last", got_q[7], fillw(207));
    end

    // read-and-clear on bank 1, N=3
    clear_logs();
    kick(8'd3, 2'd1, 1'b0, 1'b1);
    wait_done(200, 1'b0);
    chk("t6_reads", 32'(rd_cyc.size()), 32'd4);
`ifdef PBUF2DDR_CLEAR_EN
    chk("t6_clr_count", 32'(clr_cyc.size()), 32'd4);
    for (int i = 0; i < clr_cyc.size() && i < 4 && i < rd_cyc.size(); i++) begin
      chk($sformatf("t6_clr_en%0d", i), 32'(clr_en_q[i]), 32'b0010);
      chk($sformatf("t6_clr_addr%0d", i), 32'(clr_addr_q[i]), 32'(i));
      chk($sformatf("t6_clr_cyc%0d", i), 32'(clr_cyc[i]), 32'(rd_cyc[i] + RD_LAT));
    end
`else
    chk("t6_clr_count", 32'(clr_cyc.size()), 32'd0);
`endif
    clear_logs();
    kick(8'd3, 2'd1, 1'b0, 1'b0);
    wait_done(200, 1'b0);
    chk("t6_reread_count", 32'(got_q.size()), 32'd4);
    mism = 0;
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
`ifdef PBUF2DDR_CLEAR_EN
      if (got_q[i] !== '0) mism++;
`else
      if (got_q[i] !== fillw(i + 200)) mism++;
`endif
    end
    chk("t6_reread_data", 32'(mism), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pbuf2ddr.md
# pbuf2ddr

Drains the four parameter-buffer banks (pbuf) into a DDR write stream. It is the outbound counterpart of the DDR-to-pbuf loader, used to write updated weights and accumulated gradients back to memory. The block issues pipelined buffer reads, absorbs the fixed read latency in a small credit-tracked FIFO, and presents words on a valid/ready stream toward the DDR write engine. An optional read-and-clear path zeroes gradient entries as they are dumped.

## Interface
Parameters:
- BUF_DEPTH, 256: entries per pbuf bank.
- ADDR_W, bw(BUF_DEPTH): pbuf address width.
- DATA_W, 16: element width.
- BATCH, 32: elements per bank word.
- DDR_W, DATA_W*BATCH: stream width. Must equal DATA_W*BATCH.
- RD_LAT, 2: pbuf read latency in cycles, from pbuf_rd_en sampled to pbuf_rd_data valid.
- FIFO_DEPTH, 4: output FIFO entries. Must be ≥ RD_LAT+2.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset. Synchronous, active-high.
- start, in, 1: one-cycle pulse that launches a transfer. Ignored while busy.
- done, out, 1: high when idle.
- conf_trans_num, in, 8: number of pbuf addresses to read, minus 1.
- conf_grp_sel, in, 2: bank to read in single-bank mode.
- conf_all_banks, in, 1: 1 selects reading banks 0..3 for every address.
- conf_clear, in, 1: request clear-after-read. Effective only with the macro.
- pbuf_rd_addr, out, ADDR_W: read address.
- pbuf_rd_en, out, 4: per-bank read enable. One-hot or zero.
- pbuf_rd_data, in, 4×DATA_W*BATCH: per-bank read data.
- pbuf_clr_addr, out, ADDR_W: clear write address.
- pbuf_clr_en, out, 4: per-bank clear write enable. Data written is zero.
- ddr_data, out, DDR_W: stream data. Lane i sits at bits [DATA_W*i +: DATA_W].
- ddr_valid, out, 1: stream valid.
- ddr_ready, in, 1: stream ready.

## Operation
- Configuration inputs are latched on start. They may change freely afterwards.
- States:
  - IDLE: done=1. start → RUN, with the address and bank counters cleared.
  - RUN: issue reads.
  - DRAIN: no more reads are issued. Wait for in-flight reads and FIFO to empty, then → IDLE.
- Issue order:
  - Single-bank mode: addresses 0..N at bank conf_grp_sel.
  - All-banks mode: bank 0..3 at addr 0, then at addr 1, and so on.
  - Word count: N+1 (single-bank) or 4(N+1) (all-banks), where N = conf_trans_num.
- Credit rule: issue a read only if in-flight + FIFO occupancy < FIFO_DEPTH. The FIFO therefore never overflows and ddr_ready backpressure never loses data.
- Return data: captured RD_LAT cycles after issue. The source bank comes from an RD_LAT-deep bank-tag shift register.
- Last issue moves RUN → DRAIN in the same cycle.
- Stream rules: once ddr_valid=1, ddr_valid and ddr_data hold until ddr_ready=1. A word transfers when both are high.
- Counters: address counter does not wrap past N. If BUF_DEPTH-1 < N, the address wraps modulo BUF_DEPTH. That is legal but undefined for the user.

## Timing
- Reset values: done=1; ddr_valid=0; ddr_data=0; pbuf_rd_en=0; pbuf_rd_addr=0; pbuf_clr_en=0; pbuf_clr_addr=0. FIFO empty, in-flight count 0, state IDLE.
- Reset mid-transfer: returns to IDLE next cycle. FIFO flushed. Pending read returns are discarded by clearing the tag valid pipeline.
- Start pulse in cycle 0:
  - done=0 in cycle 1.
  - First pbuf_rd_en in cycle 1 (outputs registered).
  - Data captured into the FIFO in cycle 1+RD_LAT.
  - First ddr_valid in cycle 2+RD_LAT.
- Throughput: 1 word/cycle with ddr_ready held high.
- done rises the cycle after the final ddr handshake.
- A start coinciding with rst is ignored. A start while done=0 is ignored.
- Simultaneous FIFO push and pop at full or empty: both happen; occupancy is unchanged.

## Configuration
- PBUF2DDR_CLEAR_EN defined, and conf_clear latched 1:
  - pbuf_clr_en pulses the captured bank with pbuf_clr_addr = read address, in the same cycle the read data is captured (issue+RD_LAT). This is the read-and-clear path.
  - The clear is never issued to an address that has a read still in flight.
- Macro undefined: pbuf_clr_en and pbuf_clr_addr are tied 0 and the conf_clear input is ignored. Streaming behaviour is identical.

## Test plan
- Single-bank stream: bank 2, N=7, bank2[a]={BATCH{a+1}}, ddr_ready=1 → 8 words of value 1..8.
  - First ddr_valid at cycle RD_LAT+2 after start.
  - No gaps between words.
  - done rises 1 cycle after the 8th handshake.
- All-banks stream: N=1, bank b addr a = 16a+b → stream order 0,1,2,3,16,17,18,19. Exactly 8 words.
- Backpressure: ddr_ready random 30% duty, N=255 → all 256 words in order with none duplicated. ddr_data stable while valid && !ready. In-flight + occupancy never exceeds 4.
- Reset at the 5th handshake of an N=15 transfer → ddr_valid=0 next cycle, done=1, no stale words. A fresh start with N=0 emits exactly 1 word.
- Start while busy: second start pulse at cycle 3 → ignored. Word count unchanged.
- Clear, macro on: conf_clear=1, bank 1, N=3 → pbuf_clr_en=4'b0010 at addrs 0..3, each RD_LAT after its read. Reading bank 1 again yields zeros. Same run with macro off: pbuf_clr_en stays 0.
